// File: rtl/fifo_piso_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_piso_reader
// Description : Pops words from a FIFO and serializes them MSB first with
//               a valid/ready handshake, counting completed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_piso_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  input  logic             fifo_push,
  output logic             fifo_pop,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       byte_count
);

  localparam int unsigned          CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]     c_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POP     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SHIFT   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [7:0]       r_byte_cnt;
  logic             w_xfer;
  logic             w_last;

  assign w_xfer     = (r_state == ST_SHIFT) && ser_ready;
  assign w_last     = w_xfer && (r_bit_cnt == c_LAST_BIT);
  assign byte_count = r_byte_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_CAPTURE) begin
        r_shift   <= fifo_data;
        r_bit_cnt <= '0;
      end else if (w_xfer) begin
        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_byte_cnt <= r_byte_cnt + 8'd1;
      end
    end
  end

  // A pop coinciding with a push is ignored by the FIFO, so POP retries.
  always_comb begin
    w_next      = r_state;
    fifo_pop    = 1'b0;
    ser_valid   = 1'b0;
    ser_out     = 1'b0;
    frame_start = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) w_next = ST_POP;
      end
      ST_POP: begin
        fifo_pop = 1'b1;
        w_next   = fifo_push ? ST_POP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_valid   = 1'b1;
        ser_out     = r_shift[WIDTH-1];
        frame_start = (r_bit_cnt == '0);
        if (w_last) w_next = fifo_empty ? ST_IDLE : ST_POP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
